uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx` instance among `NUM_REQ` byte producers (command responder, status reporter, debug echo, etc.). It accepts one byte at a time over per-requester valid/ready handshakes and launches exactly one UART frame per accepted byte. It reports per-requester completion and enforces a watchdog on the transmitter. It sits between the producers and the single TX serializer, alongside `uart_rx`, in the UART subsystem.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART subsystem types and constants.
// Used by the TX arbiter, uart_tx and uart_rx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_START,
        ARB_WAIT_BUSY,
        ARB_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer and transmitter side signals of the TX arbiter.
// slave is the arbiter view; master is the environment view.
interface uart_tx_arbiter_if import uart_pkg::*; #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = UART_DATA_BITS
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_done;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_busy;
    logic                         tx_done;
    logic [GW-1:0]                grant_id;
    logic                         active;
    logic                         timeout_err;

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, req_done, tx_start, tx_data,
        output grant_id, active, timeout_err
    );

    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, req_done, tx_start, tx_data,
        input  grant_id, active, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req
// searching upward from ptr, wrapping at N.
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [GW-1:0] idx_o,
    output logic          any_o
);
    logic [GW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = GW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte
// producers, with per-frame completion pulses and a TX watchdog.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int TIMEOUT   = 1_000_000
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t           state_q, state_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        gid_q, gid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CW-1:0]        wd_q, wd_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 terr_q, terr_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [GW-1:0]        pick_idx;
    logic                 pick_any;
    logic [GW-1:0]        nxt_ptr;
    logic                 expired;

    rr_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign nxt_ptr = (gid_q == GW'(NUM_REQ - 1)) ? '0 : gid_q + GW'(1);
    assign expired = (wd_q >= CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        wd_d    = wd_q;
        done_d  = '0;
        terr_d  = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    data_d  = bus.req_data[pick_idx*DATA_BITS +: DATA_BITS];
                    gid_d   = pick_idx;
                    state_d = ARB_START;
                end
            end
            ARB_START: begin
                wd_d    = '0;
                state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY, ARB_WAIT_DONE: begin
                wd_d = expired ? wd_q : wd_q + CW'(1);
                // Completion takes priority over a coincident expiry.
                if (bus.tx_done) begin
                    done_d[gid_q] = 1'b1;
                    ptr_d         = nxt_ptr;
                    state_d       = ARB_IDLE;
                end else if (expired) begin
                    terr_d  = 1'b1;
                    ptr_d   = nxt_ptr;
                    state_d = ARB_IDLE;
                end else if (state_q == ARB_WAIT_BUSY && bus.tx_busy) begin
                    state_d = ARB_WAIT_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
            wd_q    <= '0;
            done_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.req_ready   = (state_q == ARB_IDLE) ? pick_oh : '0;
    assign bus.req_done    = done_q;
    assign bus.tx_start    = (state_q == ARB_START);
    assign bus.tx_data     = data_q;
    assign bus.grant_id    = gid_q;
    assign bus.active      = (state_q != ARB_IDLE);
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the bench plays the
// producers and a simple uart_tx handshake model.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .DATA_BITS (8),
        .TIMEOUT   (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transfer at the next edge, then a normal busy/done frame.
    task automatic run_frame(input int k, input logic [7:0] d,
                             input logic [3:0] v_after);
        chk("ready", 64'(bus.req_ready), 64'(1) << k);
        tick();
        bus.req_valid = v_after;
        #1;
        chk("start", 64'(bus.tx_start), 64'(1));
        chk("gid", 64'(bus.grant_id), 64'(k));
        chk("data", 64'(bus.tx_data), 64'(d));
        chk("ready_start", 64'(bus.req_ready), 64'(0));
        tick();
        chk("start_off", 64'(bus.tx_start), 64'(0));
        bus.tx_busy = 1'b1;
        tick();
        tick();
        chk("ready_busy", 64'(bus.req_ready), 64'(0));
        chk("data_hold", 64'(bus.tx_data), 64'(d));
        bus.tx_done = 1'b1;
        bus.tx_busy = 1'b0;
        tick();
        bus.tx_done = 1'b0;
        #1;
        chk("done", 64'(bus.req_done), 64'(1) << k);
        chk("idle", 64'(bus.active), 64'(0));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_start", 64'(bus.tx_start), 64'(0));
        chk("rst_active", 64'(bus.active), 64'(0));
        chk("rst_gid", 64'(bus.grant_id), 64'(0));
        chk("rst_data", 64'(bus.tx_data), 64'(0));
        chk("rst_done", 64'(bus.req_done), 64'(0));
        chk("rst_terr", 64'(bus.timeout_err), 64'(0));
        chk("rst_ready", 64'(bus.req_ready), 64'(0));

        // Single requester 2 sends 0x55; ptr then 3
        bus.req_data  = 32'h0055_0000;
        bus.req_valid = 4'b0100;
        #1;
        run_frame(2, 8'h55, 4'b0000);
        bus.req_data  = 32'hA3A2_A1A0;
        bus.req_valid = 4'b1111;
        #1;
        chk("ptr_after_2", 64'(bus.req_ready), 64'h8);

        // All four continuously, after reset: 0,1,2,3,0
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        run_frame(0, 8'hA0, 4'b1111);
        run_frame(1, 8'hA1, 4'b1111);
        run_frame(2, 8'hA2, 4'b1111);
        run_frame(3, 8'hA3, 4'b1111);
        run_frame(0, 8'hA0, 4'b1111);

        // Watchdog: tx_busy stays 0, requester 1 (ptr is 1)
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_3C00;
        #1;
        chk("wd_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 4'b0000;
        repeat (101) tick();
        chk("wd_early", 64'(bus.timeout_err), 64'(0));
        chk("wd_active", 64'(bus.active), 64'(1));
        tick();
        chk("wd_terr", 64'(bus.timeout_err), 64'(1));
        chk("wd_nodone", 64'(bus.req_done), 64'(0));
        chk("wd_idle", 64'(bus.active), 64'(0));
        bus.req_data  = 32'hA3A2_A1A0;
        bus.req_valid = 4'b1111;
        #1;
        chk("wd_ptr", 64'(bus.req_ready), 64'h4);
        tick();
        chk("wd_pulse", 64'(bus.timeout_err), 64'(0));

        // Same-cycle tx_done and expiry: requester 2 now granted
        chk("tie_gid", 64'(bus.grant_id), 64'(2));
        bus.req_valid = 4'b0000;
        repeat (101) tick();
        chk("tie_pending", 64'(bus.active), 64'(1));
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("tie_done", 64'(bus.req_done), 64'h4);
        chk("tie_terr", 64'(bus.timeout_err), 64'(0));
        tick();
        chk("tie_terr2", 64'(bus.timeout_err), 64'(0));

        // Reset in WAIT_DONE; ptr was 3
        bus.req_valid = 4'b1000;
        #1;
        chk("rw_ready", 64'(bus.req_ready), 64'h8);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        bus.tx_busy = 1'b1;
        tick();
        tick();
        chk("rw_active", 64'(bus.active), 64'(1));
        rst = 1'b1;
        bus.tx_done = 1'b1;
        tick();
        rst = 1'b0;
        bus.tx_done = 1'b0;
        bus.tx_busy = 1'b0;
        #1;
        chk("rw_active0", 64'(bus.active), 64'(0));
        chk("rw_gid", 64'(bus.grant_id), 64'(0));
        chk("rw_data", 64'(bus.tx_data), 64'(0));
        chk("rw_done", 64'(bus.req_done), 64'(0));
        chk("rw_terr", 64'(bus.timeout_err), 64'(0));
        chk("rw_start", 64'(bus.tx_start), 64'(0));
        bus.req_valid = 4'b1111;
        #1;
        chk("rw_from0", 64'(bus.req_ready), 64'h1);

        // Requester 0 drops, 3 raises while busy
        bus.req_valid = 4'b0001;
        #1;
        run_frame(0, 8'hA0, 4'b1000);
        run_frame(3, 8'hA3, 4'b0000);
        tick();
        chk("end_done", 64'(bus.req_done), 64'(0));
        chk("end_idle", 64'(bus.active), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
